// File: rtl/state_wr_arbiter.sv
// Shares the regfile_state random-write port between a FIFO-buffered host loader and
// accelerator_fsm writeback; optional per-source write counters under STATE_ARB_STATS_EN.
module state_wr_arbiter #(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned DATA_W     = 18,
`ifdef STATE_ARB_STATS_EN
   parameter int unsigned CNT_W      = 16,
`endif
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start_req_i,
   input  logic                         done_i,
   input  logic                         host_valid_i,
   output logic                         host_ready_o,
   input  logic [ADDR_W-1:0]            host_addr_i,
   input  logic [DATA_W-1:0]            host_data_i,
   input  logic                         fsm_we_i,
   input  logic [ADDR_W-1:0]            fsm_addr_i,
   input  logic [DATA_W-1:0]            fsm_data_i,
   output logic                         ran_we_o,
   output logic [ADDR_W-1:0]            ran_w_addr_o,
   output logic [DATA_W-1:0]            ran_w_data_o,
   output logic                         acc_start_o,
   output logic                         busy_o,
   output logic                         err_o,
`ifdef STATE_ARB_STATS_EN
   output logic [CNT_W-1:0]             host_wr_cnt_o,
   output logic [CNT_W-1:0]             fsm_wr_cnt_o,
`endif
   output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {StIdle, StDrain, StRun} state_e;

   state_e            state_q;
   logic              acc_start_q, busy_q, err_q;
   logic              ran_we_q;
   logic [ADDR_W-1:0] ran_addr_q;
   logic [DATA_W-1:0] ran_data_q;

   logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0]  cnt_q;

   logic push, pop, fsm_fwd;

   assign host_ready_o = (state_q == StIdle) && (cnt_q < OCC_W'(FIFO_DEPTH));
   assign push         = host_valid_i && host_ready_o;
   // Writeback owns the port: any fsm strobe blocks the pop, even a dropped one.
   assign pop          = (cnt_q != '0) && (state_q != StRun) && !fsm_we_i;
   assign fsm_fwd      = fsm_we_i && (state_q == StRun);

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= host_addr_i;
         data_mem[wr_ptr_q] <= host_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         acc_start_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         ran_we_q    <= 1'b0;
         ran_addr_q  <= '0;
         ran_data_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop) begin
            cnt_q <= cnt_q + OCC_W'(1);
         end else if (pop && !push) begin
            cnt_q <= cnt_q - OCC_W'(1);
         end

         ran_we_q <= pop || fsm_fwd;
         if (fsm_fwd) begin
            ran_addr_q <= fsm_addr_i;
            ran_data_q <= fsm_data_i;
         end else if (pop) begin
            ran_addr_q <= addr_mem[rd_ptr_q];
            ran_data_q <= data_mem[rd_ptr_q];
         end

         if (fsm_we_i && (state_q != StRun)) err_q <= 1'b1;

         unique case (state_q)
            StIdle: begin
               if (start_req_i) begin
                  state_q <= StDrain;
                  busy_q  <= 1'b1;
               end
            end
            StDrain: begin
               if (!start_req_i) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (cnt_q == '0) begin
                  // The last host write was popped earlier, so it leaves before any writeback.
                  state_q     <= StRun;
                  acc_start_q <= 1'b1;
               end
            end
            StRun: begin
               if (done_i || !start_req_i) begin
                  state_q     <= StIdle;
                  busy_q      <= 1'b0;
                  acc_start_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= StIdle;
               busy_q      <= 1'b0;
               acc_start_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef STATE_ARB_STATS_EN
   logic [CNT_W-1:0] host_wr_cnt_q, fsm_wr_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         host_wr_cnt_q <= '0;
         fsm_wr_cnt_q  <= '0;
      end else begin
         if (pop && (host_wr_cnt_q != '1))    host_wr_cnt_q <= host_wr_cnt_q + CNT_W'(1);
         if (fsm_fwd && (fsm_wr_cnt_q != '1)) fsm_wr_cnt_q  <= fsm_wr_cnt_q + CNT_W'(1);
      end
   end

   assign host_wr_cnt_o = host_wr_cnt_q;
   assign fsm_wr_cnt_o  = fsm_wr_cnt_q;
`endif

   assign ran_we_o     = ran_we_q;
   assign ran_w_addr_o = ran_addr_q;
   assign ran_w_data_o = ran_data_q;
   assign acc_start_o  = acc_start_q;
   assign busy_o       = busy_q;
   assign err_o        = err_q;
   assign fifo_cnt_o   = cnt_q;

endmodule

// File: tb/tb_state_wr_arbiter.sv
// Bench for state_wr_arbiter: vector table, hand sequences for gating/run/reset, and
// randomized traffic against a queue-based reference model.
module tb_state_wr_arbiter;

   localparam int AW    = 12;
   localparam int DW    = 18;
   localparam int DEPTH = 4;
`ifdef STATE_ARB_STATS_EN
   localparam int CW    = 2;
`endif
   localparam int M_IDLE = 0, M_DRAIN = 1, M_RUN = 2;

   logic          clk, rst_n;
   logic          start_req_i, done_i, host_valid_i, host_ready_o;
   logic [AW-1:0] host_addr_i, fsm_addr_i, ran_w_addr_o;
   logic [DW-1:0] host_data_i, fsm_data_i, ran_w_data_o;
   logic          fsm_we_i, ran_we_o, acc_start_o, busy_o, err_o;
   logic [2:0]    fifo_cnt_o;
`ifdef STATE_ARB_STATS_EN
   logic [CW-1:0] host_wr_cnt_o, fsm_wr_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   state_wr_arbiter #(
      .ADDR_W(AW),
      .DATA_W(DW),
`ifdef STATE_ARB_STATS_EN
      .CNT_W(CW),
`endif
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start_req_i(start_req_i),
      .done_i(done_i),
      .host_valid_i(host_valid_i),
      .host_ready_o(host_ready_o),
      .host_addr_i(host_addr_i),
      .host_data_i(host_data_i),
      .fsm_we_i(fsm_we_i),
      .fsm_addr_i(fsm_addr_i),
      .fsm_data_i(fsm_data_i),
      .ran_we_o(ran_we_o),
      .ran_w_addr_o(ran_w_addr_o),
      .ran_w_data_o(ran_w_data_o),
      .acc_start_o(acc_start_o),
      .busy_o(busy_o),
      .err_o(err_o),
`ifdef STATE_ARB_STATS_EN
      .host_wr_cnt_o(host_wr_cnt_o),
      .fsm_wr_cnt_o(fsm_wr_cnt_o),
`endif
      .fifo_cnt_o(fifo_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          start, done, hv;
      logic [AW-1:0] ha;
      logic [DW-1:0] hd;
      logic          fwe;
      logic [AW-1:0] fa;
      logic [DW-1:0] fd;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      logic          e_acc, e_busy, e_err;
      logic [2:0]    e_cnt;
      logic          e_rdy;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(input int s, input int d, input int hv, input logic [AW-1:0] ha,
                               input logic [DW-1:0] hd, input int fwe, input logic [AW-1:0] fa,
                               input logic [DW-1:0] fd, input int we, input logic [AW-1:0] ea,
                               input logic [DW-1:0] ed, input int acc, input int busy,
                               input int err, input int cnt, input int rdy);
      vec_t v;
      v.start = 1'(s);   v.done = 1'(d);     v.hv = 1'(hv);
      v.ha = ha;         v.hd = hd;          v.fwe = 1'(fwe);
      v.fa = fa;         v.fd = fd;          v.e_we = 1'(we);
      v.e_addr = ea;     v.e_data = ed;      v.e_acc = 1'(acc);
      v.e_busy = 1'(busy); v.e_err = 1'(err); v.e_cnt = 3'(cnt);
      v.e_rdy = 1'(rdy);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic d, input logic hv, input logic [AW-1:0] ha,
                        input logic [DW-1:0] hd, input logic fwe, input logic [AW-1:0] fa,
                        input logic [DW-1:0] fd);
      start_req_i = s; done_i = d; host_valid_i = hv; host_addr_i = ha; host_data_i = hd;
      fsm_we_i = fwe; fsm_addr_i = fa; fsm_data_i = fd;
   endtask

   task automatic expect_out(input string tag, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic acc, input logic busy,
                             input logic err, input logic [2:0] cnt, input logic rdy);
      chk($sformatf("%s.we", tag), ran_we_o, we);
      chk($sformatf("%s.addr", tag), ran_w_addr_o, a);
      chk($sformatf("%s.data", tag), ran_w_data_o, d);
      chk($sformatf("%s.acc", tag), acc_start_o, acc);
      chk($sformatf("%s.busy", tag), busy_o, busy);
      chk($sformatf("%s.err", tag), err_o, err);
      chk($sformatf("%s.cnt", tag), fifo_cnt_o, cnt);
      chk($sformatf("%s.ready", tag), host_ready_o, rdy);
   endtask

   // Reference model: host FIFO as a queue, expected output register contents, mode as int.
   logic [AW+DW-1:0] mq[$];
   int               m_state;
   logic             m_we, m_err;
   logic [AW-1:0]    m_addr;
   logic [DW-1:0]    m_data;
`ifdef STATE_ARB_STATS_EN
   int               m_host_cnt, m_fsm_cnt;
   localparam int    CMAX = (1 << CW) - 1;
`endif

   task automatic model_reset();
      mq.delete();
      m_state = M_IDLE; m_we = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0;
`ifdef STATE_ARB_STATS_EN
      m_host_cnt = 0; m_fsm_cnt = 0;
`endif
   endtask

   task automatic model_step();
      int               sz;
      bit               rdy, push, pop, fwd;
      logic [AW+DW-1:0] e;
      sz   = mq.size();
      rdy  = (m_state == M_IDLE) && (sz < DEPTH);
      push = host_valid_i && rdy;
      pop  = (sz > 0) && (m_state != M_RUN) && !fsm_we_i;
      fwd  = fsm_we_i && (m_state == M_RUN);
      m_we = pop || fwd;
      if (fwd) begin
         m_addr = fsm_addr_i; m_data = fsm_data_i;
`ifdef STATE_ARB_STATS_EN
         if (m_fsm_cnt < CMAX) m_fsm_cnt++;
`endif
      end else if (pop) begin
         e = mq.pop_front();
         m_addr = e[AW+DW-1:DW]; m_data = e[DW-1:0];
`ifdef STATE_ARB_STATS_EN
         if (m_host_cnt < CMAX) m_host_cnt++;
`endif
      end
      if (fsm_we_i && (m_state != M_RUN)) m_err = 1'b1;
      if (push) mq.push_back({host_addr_i, host_data_i});
      case (m_state)
         M_IDLE:  if (start_req_i) m_state = M_DRAIN;
         M_DRAIN: if (!start_req_i) m_state = M_IDLE; else if (sz == 0) m_state = M_RUN;
         default: if (done_i || !start_req_i) m_state = M_IDLE;
      endcase
   endtask

   task automatic check_model(input int c);
      string t;
      t = $sformatf("rnd%0d", c);
      chk({t, ".we"}, ran_we_o, m_we);
      chk({t, ".addr"}, ran_w_addr_o, m_addr);
      chk({t, ".data"}, ran_w_data_o, m_data);
      chk({t, ".acc"}, acc_start_o, m_state == M_RUN);
      chk({t, ".busy"}, busy_o, m_state != M_IDLE);
      chk({t, ".err"}, err_o, m_err);
      chk({t, ".cnt"}, fifo_cnt_o, mq.size());
      chk({t, ".ready"}, host_ready_o, (m_state == M_IDLE) && (mq.size() < DEPTH));
`ifdef STATE_ARB_STATS_EN
      chk({t, ".hcnt"}, host_wr_cnt_o, m_host_cnt);
      chk({t, ".fcnt"}, fsm_wr_cnt_o, m_fsm_cnt);
`endif
   endtask

   initial begin
      localparam logic [AW-1:0] FA = 12'hABC;
      localparam logic [DW-1:0] FD = 18'h15555;
      localparam logic [AW-1:0] A0 = 12'h0;
      localparam logic [DW-1:0] D0 = 18'h0;

      // Load: three writes, then full FIFO with pops blocked by a stray fsm strobe.
      vecs[0]  = mk(0, 0, 1, 12'h001, 18'h3FFFF, 0, A0, D0, 0, 12'h000, 18'h00000, 0, 0, 0, 1, 1);
      vecs[1]  = mk(0, 0, 1, 12'h002, 18'h00001, 0, A0, D0, 1, 12'h001, 18'h3FFFF, 0, 0, 0, 1, 1);
      vecs[2]  = mk(0, 0, 1, 12'hFFF, 18'h2AAAA, 0, A0, D0, 1, 12'h002, 18'h00001, 0, 0, 0, 1, 1);
      vecs[3]  = mk(0, 0, 0, A0, D0, 0, A0, D0, 1, 12'hFFF, 18'h2AAAA, 0, 0, 0, 0, 1);
      vecs[4]  = mk(0, 0, 0, A0, D0, 0, A0, D0, 0, 12'hFFF, 18'h2AAAA, 0, 0, 0, 0, 1);
      vecs[5]  = mk(0, 0, 1, 12'h010, 18'h00010, 1, FA, FD, 0, 12'hFFF, 18'h2AAAA, 0, 0, 1, 1, 1);
      vecs[6]  = mk(0, 0, 1, 12'h011, 18'h00011, 1, FA, FD, 0, 12'hFFF, 18'h2AAAA, 0, 0, 1, 2, 1);
      vecs[7]  = mk(0, 0, 1, 12'h012, 18'h00012, 1, FA, FD, 0, 12'hFFF, 18'h2AAAA, 0, 0, 1, 3, 1);
      vecs[8]  = mk(0, 0, 1, 12'h013, 18'h00013, 1, FA, FD, 0, 12'hFFF, 18'h2AAAA, 0, 0, 1, 4, 0);
      vecs[9]  = mk(0, 0, 1, 12'h014, 18'h00014, 1, FA, FD, 0, 12'hFFF, 18'h2AAAA, 0, 0, 1, 4, 0);
      vecs[10] = mk(0, 0, 1, 12'h014, 18'h00014, 0, A0, D0, 1, 12'h010, 18'h00010, 0, 0, 1, 3, 1);
      vecs[11] = mk(0, 0, 1, 12'h014, 18'h00014, 0, A0, D0, 1, 12'h011, 18'h00011, 0, 0, 1, 3, 1);
      vecs[12] = mk(0, 0, 0, A0, D0, 0, A0, D0, 1, 12'h012, 18'h00012, 0, 0, 1, 2, 1);
      vecs[13] = mk(0, 0, 0, A0, D0, 0, A0, D0, 1, 12'h013, 18'h00013, 0, 0, 1, 1, 1);
      vecs[14] = mk(0, 0, 0, A0, D0, 0, A0, D0, 1, 12'h014, 18'h00014, 0, 0, 1, 0, 1);
      vecs[15] = mk(0, 0, 0, A0, D0, 0, A0, D0, 0, 12'h014, 18'h00014, 0, 0, 1, 0, 1);

      rst_n = 1'b0;
      drive(0, 0, 0, A0, D0, 0, A0, D0);
      #1;
      chk("rst.we", ran_we_o, 0);
      chk("rst.addr", ran_w_addr_o, 0);
      chk("rst.data", ran_w_data_o, 0);
      chk("rst.acc", acc_start_o, 0);
      chk("rst.busy", busy_o, 0);
      chk("rst.err", err_o, 0);
      chk("rst.cnt", fifo_cnt_o, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      expect_out("post_rst", 0, A0, D0, 0, 0, 0, 0, 1);

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].start, vecs[i].done, vecs[i].hv, vecs[i].ha, vecs[i].hd, vecs[i].fwe,
               vecs[i].fa, vecs[i].fd);
         tick();
         expect_out($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data,
                    vecs[i].e_acc, vecs[i].e_busy, vecs[i].e_err, vecs[i].e_cnt, vecs[i].e_rdy);
      end
`ifdef STATE_ARB_STATS_EN
      chk("stats.host_sat", host_wr_cnt_o, 3);
      chk("stats.fsm_zero", fsm_wr_cnt_o, 0);
`endif

      // Start gating with two entries queued; host held off during DRAIN/RUN.
      drive(0, 0, 1, 12'h0A1, 18'h11111, 1, FA, FD); tick();
      expect_out("gate.p1", 0, 12'h014, 18'h00014, 0, 0, 1, 1, 1);
      drive(0, 0, 1, 12'h0A2, 18'h22222, 1, FA, FD); tick();
      expect_out("gate.p2", 0, 12'h014, 18'h00014, 0, 0, 1, 2, 1);
      drive(1, 0, 0, A0, D0, 0, A0, D0); tick();
      expect_out("gate.d1", 1, 12'h0A1, 18'h11111, 0, 1, 1, 1, 0);
      drive(1, 0, 1, 12'hBAD, 18'h0BAD0, 0, A0, D0); tick();
      expect_out("gate.d2", 1, 12'h0A2, 18'h22222, 0, 1, 1, 0, 0);
      tick();
      expect_out("gate.run", 0, 12'h0A2, 18'h22222, 1, 1, 1, 0, 0);
      // Abort by dropping the request; the same-cycle writeback still goes out.
      drive(0, 0, 0, A0, D0, 1, 12'h3C3, 18'h0F0F0); tick();
      expect_out("abort", 1, 12'h3C3, 18'h0F0F0, 0, 0, 1, 0, 1);
      drive(0, 0, 0, A0, D0, 0, A0, D0); tick();
      expect_out("abort.idle", 0, 12'h3C3, 18'h0F0F0, 0, 0, 1, 0, 1);

      // Reset with three entries queued.
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 12'h050 + 12'(i), 18'h00050 + 18'(i), 1, FA, FD);
         tick();
      end
      chk("rst3.cnt", fifo_cnt_o, 3);
      drive(0, 0, 0, A0, D0, 0, A0, D0);
      rst_n = 1'b0;
      #1;
      chk("rst3.we", ran_we_o, 0);
      chk("rst3.addr", ran_w_addr_o, 0);
      chk("rst3.data", ran_w_data_o, 0);
      chk("rst3.err", err_o, 0);
      chk("rst3.cnt0", fifo_cnt_o, 0);
      tick();
      rst_n = 1'b1;
      tick();
      expect_out("rst3.after", 0, A0, D0, 0, 0, 0, 0, 1);

      // Run: ten back-to-back writebacks, done with the tenth.
      drive(1, 0, 0, A0, D0, 0, A0, D0); tick();
      expect_out("run.drain", 0, A0, D0, 0, 1, 0, 0, 0);
      tick();
      expect_out("run.start", 0, A0, D0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         drive(1, i == 9, 0, A0, D0, 1, 12'h100 + 12'(i), 18'h3F000 + 18'(i));
         tick();
         expect_out($sformatf("run%0d", i), 1, 12'h100 + 12'(i), 18'h3F000 + 18'(i),
                    i < 9, i < 9, 0, 0, i == 9);
      end
      drive(0, 0, 0, A0, D0, 0, A0, D0); tick();
      expect_out("run.end", 0, 12'h109, 18'h3F009, 0, 0, 0, 0, 1);

      // Randomized traffic against the reference model, with occasional async resets.
      rst_n = 1'b0;
      #1;
      model_reset();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         check_model(c);
         if ($urandom_range(0, 249) == 0) begin
            rst_n = 1'b0;
            #2;
            model_reset();
            check_model(c);
            rst_n = 1'b1;
         end
         if ($urandom_range(0, 7) == 0) start_req_i = ~start_req_i;
         done_i       = ($urandom_range(0, 15) == 0);
         host_valid_i = ($urandom_range(0, 9) < 6);
         host_addr_i  = AW'($urandom);
         host_data_i  = DW'($urandom);
         fsm_we_i     = (m_state == M_RUN) ? ($urandom_range(0, 3) != 0)
                                           : ($urandom_range(0, 59) == 0);
         fsm_addr_i   = AW'($urandom);
         fsm_data_i   = DW'($urandom);
         model_step();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
